// File: rtl/mem_rq_pkg.sv
// Shared definitions for the core memory-request router: request layout,
// MMIO register addresses and the bus-error response word.
package mem_rq_pkg;

    localparam int ADDR_HI = 64;
    localparam int ADDR_LO = 33;
    localparam int WE_BIT  = 32;

    typedef struct packed {
        logic [ADDR_HI-ADDR_LO:0] addr;
        logic                     iswrite;
        logic [WE_BIT-1:0]        data;
    } mem_rq_t;

    localparam logic [31:0] GPIO_ADDR       = 32'h1001_200c;
    localparam logic [31:0] SPI_TXDATA_ADDR = 32'h1002_4048;
    localparam logic [31:0] SPI_RXDATA_ADDR = 32'h1002_404c;
    localparam logic [31:0] SPI_CSMODE_ADDR = 32'h1002_4018;

    localparam logic [31:0] BUSERR_WORD = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_rs_fifo.sv
// Synchronous response FIFO, depth 2**LG_DEPTH, with occupancy count.
module mem_rs_fifo #(
    parameter int WIDTH    = 32,
    parameter int LG_DEPTH = 1
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 wr_en,
    input  logic [WIDTH-1:0]     wr_data,
    input  logic                 rd_en,
    output logic [WIDTH-1:0]     rd_data,
    output logic [LG_DEPTH:0]    count,
    output logic                 full,
    output logic                 empty
);

    localparam int unsigned DEPTH = 1 << LG_DEPTH;
    localparam logic [LG_DEPTH:0] DEPTH_C = DEPTH[LG_DEPTH:0];

    logic [WIDTH-1:0]    mem_q [DEPTH];
    logic [LG_DEPTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [LG_DEPTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [LG_DEPTH:0]   count_q, count_d;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + LG_DEPTH'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + LG_DEPTH'(1);
        case ({wr_en, rd_en})
            2'b10:   count_d = count_q + (LG_DEPTH+1)'(1);
            2'b01:   count_d = count_q - (LG_DEPTH+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage is data only; validity is tracked entirely by the pointers.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wr_data;
    end

    assign rd_data = mem_q[rd_ptr_q];
    assign count   = count_q;
    assign full    = (count_q == DEPTH_C);
    assign empty   = (count_q == '0);

    no_overflow: assert property (@(posedge clk) disable iff (!resetn) !(wr_en && full));

endmodule

// File: rtl/mem_rq_router.sv
// Routes core memory requests to BRAM or MMIO and returns in-order responses.
// Optional build macro MEM_RQ_BUSERR_EN: unmapped MMIO answers BUSERR_WORD and sets bus_err.
module mem_rq_router
    import mem_rq_pkg::*;
#(
    parameter int LGSZW        = 12,
    parameter int LG_RSQ_DEPTH = 1
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               rq_valid,
    input  logic [64:0]        rq,
    output logic               rq_take,
    input  logic               rs_rdy,
    output logic               rs_en,
    output logic [31:0]        rs,
    output logic               ram_rq_en,
    output logic [LGSZW+1:0]   ram_addr,
    output logic               ram_we,
    output logic [31:0]        ram_wdata,
    input  logic               ram_rs_en,
    input  logic [31:0]        ram_rdata,
    output logic               io_rq_en,
    output logic [31:0]        io_addr,
    output logic               io_we,
    output logic [31:0]        io_wdata,
`ifdef MEM_RQ_BUSERR_EN
    output logic               bus_err,
`endif
    input  logic               io_hit,
    input  logic [31:0]        io_rdata
);

    localparam int unsigned DEPTH = 1 << LG_RSQ_DEPTH;
    localparam logic [LG_RSQ_DEPTH+1:0] DEPTH_C = DEPTH[LG_RSQ_DEPTH+1:0];

    mem_rq_t                 req;
    logic                    is_ram;
    logic                    ram_pending_q, ram_pending_d;
    logic [LG_RSQ_DEPTH:0]   q_count;
    logic [LG_RSQ_DEPTH+1:0] occupancy;
    logic                    credit;
    logic                    q_full, q_empty;
    logic                    enq_en;
    logic [31:0]             enq_data;

    assign req    = rq;
    assign is_ram = ((req.addr >> (LGSZW + 2)) == 32'd0);

    // Outstanding BRAM reply reserves a slot; a dequeue this cycle is not counted.
    assign occupancy = {1'b0, q_count} + {{(LG_RSQ_DEPTH+1){1'b0}}, ram_pending_q};
    assign credit    = (occupancy < DEPTH_C);

    assign rq_take   = resetn & rq_valid & credit & ~(~is_ram & ram_pending_q);
    assign ram_rq_en = rq_take & is_ram;
    assign io_rq_en  = rq_take & ~is_ram;

    assign ram_addr  = req.addr[LGSZW+1:0];
    assign ram_we    = req.iswrite;
    assign ram_wdata = req.data;
    assign io_addr   = req.addr;
    assign io_we     = req.iswrite;
    assign io_wdata  = req.data;

    always_comb begin
        ram_pending_d = ram_rq_en;
        enq_en        = ram_rs_en | io_rq_en;
        enq_data      = ram_rdata;
        if (!ram_rs_en) begin
            enq_data = io_we ? 32'h0 : io_rdata;
`ifdef MEM_RQ_BUSERR_EN
            if (!io_hit) enq_data = BUSERR_WORD;
`endif
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ram_pending_q <= 1'b0;
        else         ram_pending_q <= ram_pending_d;
    end

`ifdef MEM_RQ_BUSERR_EN
    logic bus_err_q, bus_err_d;

    always_comb begin
        bus_err_d = bus_err_q | (io_rq_en & ~io_hit);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) bus_err_q <= 1'b0;
        else         bus_err_q <= bus_err_d;
    end

    assign bus_err = bus_err_q;
`else
    logic unused_io_hit;
    assign unused_io_hit = io_hit;
`endif

    assign rs_en = ~q_empty & rs_rdy;

    mem_rs_fifo #(
        .WIDTH    (32),
        .LG_DEPTH (LG_RSQ_DEPTH)
    ) u_rs_fifo (
        .clk     (clk),
        .resetn  (resetn),
        .wr_en   (enq_en),
        .wr_data (enq_data),
        .rd_en   (rs_en),
        .rd_data (rs),
        .count   (q_count),
        .full    (q_full),
        .empty   (q_empty)
    );

    ram_rs_protocol: assert property (@(posedge clk) disable iff (!resetn) ram_rs_en |-> ram_pending_q);
    io_ram_exclusive: assert property (@(posedge clk) disable iff (!resetn) !(ram_rs_en && io_rq_en));

endmodule
